// File: rtl/riscv_if_stage_if.sv
// Bundle of the fetch stage's redirect, instruction-memory and decode-side signals.
// The master modport is the fetch stage; the slave modport is its surroundings.
interface riscv_if_stage_if;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        redirect_misaligned;

    modport master (
        input  branch_taken, branch_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, redirect_misaligned
    );

    modport slave (
        output branch_taken, branch_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, redirect_misaligned
    );
endinterface

// File: rtl/riscv_if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order word fetches,
// buffers responses for decode, and flushes/drops wrong-path work on a redirect.
module riscv_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    riscv_if_stage_if.master  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          mis_q, mis_d;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          req_fire;
    logic          deq;
    logic          push;
    logic [CW:0]   used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both in-flight requests and buffered entries, so a push can never overflow.
    always_comb begin
        used                    = {1'b0, outst_q} + {1'b0, cnt_q};
        bus.imem_req_valid      = rst_n & ~bus.branch_taken & (used < (CW+1)'(DEPTH));
        bus.imem_req_addr       = fetch_pc_q;
        bus.if_valid            = rst_n & ~bus.branch_taken & (cnt_q != '0);
        bus.if_pc               = pc_mem[rd_ptr_q];
        bus.if_instr            = instr_mem[rd_ptr_q];
        bus.redirect_misaligned = mis_q;
        req_fire                = bus.imem_req_valid & bus.imem_req_ready;
        deq                     = bus.if_valid & bus.if_ready;
        push                    = bus.imem_rsp_valid & (drop_q == '0) & ~bus.branch_taken;
    end

    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        mis_d      = bus.branch_taken & (|bus.branch_target[1:0]);

        if (bus.branch_taken) begin
            fetch_pc_d = {bus.branch_target[31:2], 2'b00};
            rsp_pc_d   = {bus.branch_target[31:2], 2'b00};
            cnt_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outst_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (bus.imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CW'(push) - CW'(deq);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            mis_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mis_q      <= mis_d;
        end
    end

    // NOTE: buffer storage is not reset; the count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= rsp_pc_q;
            instr_mem[wr_ptr_q] <= bus.imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_riscv_if_stage.sv
// Self-checking bench for riscv_if_stage: random memory/decode/redirect traffic against a
// queue-based model of the fetch rules, plus directed scenarios pinned by literal values.
module tb_riscv_if_stage;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    riscv_if_stage_if bus ();

    riscv_if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fent_t;

    mreq_t       mq[$];
    fent_t       fq[$];
    logic [31:0] req_log[$];
    logic [31:0] deq_log[$];
    logic [31:0] exp_fetch_pc;
    logic        exp_mis;
    int          mis_cnt;
    int          cyc;
    int          checks;
    int          errors;
    int          rdy_pct;
    int          rsp_pct;
    int          ifr_pct;
    bit          force_rsp;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n              = 1'b0;
            bus.branch_taken   = 1'b0;
            bus.branch_target  = $urandom;
            bus.imem_req_ready = 1'b1;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
            bus.if_ready       = 1'b1;
            #1;
            check("reset_req_valid", bus.imem_req_valid, 1'b0);
            check("reset_if_valid", bus.if_valid, 1'b0);
            cyc++;
        end
        mq.delete();
        fq.delete();
        exp_fetch_pc = 32'h0000_0000;
        exp_mis      = 1'b0;
    endtask

    task automatic step(input bit bt, input logic [31:0] tgt);
        bit    rv, rdy, ifr, exp_rv, exp_iv, fire, deq;
        mreq_t e;
        @(negedge clk);
        rst_n = 1'b1;
        rv  = (mq.size() > 0) && (mq[0].cyc < cyc) &&
              (force_rsp || ($urandom_range(99) < rsp_pct));
        force_rsp = 1'b0;
        rdy = $urandom_range(99) < rdy_pct;
        ifr = $urandom_range(99) < ifr_pct;
        bus.branch_taken   = bt;
        bus.branch_target  = tgt;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rv ? mq[0].data : $urandom;
        bus.if_ready       = ifr;
        #1;
        exp_rv = !bt && (mq.size() + fq.size() < DEPTH);
        exp_iv = !bt && (fq.size() != 0);
        check("req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", bus.imem_req_addr, exp_fetch_pc);
        check("if_valid", bus.if_valid, exp_iv);
        if (exp_iv) begin
            check("if_pc", bus.if_pc, fq[0].pc);
            check("if_instr", bus.if_instr, fq[0].instr);
        end
        check("misaligned", bus.redirect_misaligned, exp_mis);

        if (bus.imem_req_valid && rdy) req_log.push_back(bus.imem_req_addr);
        if (bus.if_valid && ifr) deq_log.push_back(bus.if_pc);
        if (bus.redirect_misaligned) mis_cnt++;

        fire = exp_rv && rdy;
        deq  = exp_iv && ifr;
        if (deq) void'(fq.pop_front());
        if (rv) begin
            e = mq.pop_front();
            if (!bt && !e.stale) fq.push_back('{pc: e.addr, instr: e.data});
        end
        if (bt) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            fq.delete();
            exp_fetch_pc = {tgt[31:2], 2'b00};
        end else if (fire) begin
            mq.push_back('{addr: exp_fetch_pc, data: instr_of(exp_fetch_pc), cyc: cyc, stale: 1'b0});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        exp_mis = bt && (tgt[1:0] != 2'b00);
        cyc++;
    endtask

    task automatic clear_logs();
        req_log.delete();
        deq_log.delete();
        mis_cnt = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] tgt;
        checks = 0; errors = 0; cyc = 0; mis_cnt = 0; force_rsp = 1'b0;
        rst_n = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = '0; bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.if_ready = 1'b0;

        // Streaming from reset with an always-ready memory and decode.
        rdy_pct = 100; rsp_pct = 100; ifr_pct = 100;
        do_reset(3);
        clear_logs();
        run(10);
        check("stream_req0", (req_log.size() > 0) ? req_log[0] : 32'hx, 32'h0000_0000);
        check("stream_req1", (req_log.size() > 1) ? req_log[1] : 32'hx, 32'h0000_0004);
        check("stream_req2", (req_log.size() > 2) ? req_log[2] : 32'hx, 32'h0000_0008);
        check("stream_pc0", (deq_log.size() > 0) ? deq_log[0] : 32'hx, 32'h0000_0000);
        check("stream_pc1", (deq_log.size() > 1) ? deq_log[1] : 32'hx, 32'h0000_0004);
        check("stream_pc2", (deq_log.size() > 2) ? deq_log[2] : 32'hx, 32'h0000_0008);

        // Decode stalled: only DEPTH requests may ever issue.
        ifr_pct = 0;
        do_reset(1);
        clear_logs();
        run(8);
        check("stall_req_count", req_log.size(), 2);
        check("stall_req1", (req_log.size() > 1) ? req_log[1] : 32'hx, 32'h0000_0004);
        ifr_pct = 100;
        run(6);

        // Redirect with two requests in flight and no response yet.
        do_reset(1);
        rsp_pct = 0;
        run(2);
        clear_logs();
        step(1'b1, 32'h0000_0100);
        rsp_pct = 100;
        run(8);
        check("redir_req0", (req_log.size() > 0) ? req_log[0] : 32'hx, 32'h0000_0100);
        check("redir_pc0", (deq_log.size() > 0) ? deq_log[0] : 32'hx, 32'h0000_0100);

        // Redirect in the same cycle as a response, another still outstanding.
        do_reset(1);
        rsp_pct = 0;
        run(2);
        clear_logs();
        force_rsp = 1'b1;
        step(1'b1, 32'h0000_0100);
        rsp_pct = 100;
        run(8);
        check("redir_rsp_pc0", (deq_log.size() > 0) ? deq_log[0] : 32'hx, 32'h0000_0100);
        check("redir_rsp_pc1", (deq_log.size() > 1) ? deq_log[1] : 32'hx, 32'h0000_0104);

        // Misaligned target is aligned down and flagged for one cycle.
        clear_logs();
        step(1'b1, 32'h0000_0206);
        run(8);
        check("mis_req0", (req_log.size() > 0) ? req_log[0] : 32'hx, 32'h0000_0204);
        check("mis_pulses", mis_cnt, 1);

        // Address wrap at the top of the 32-bit space.
        clear_logs();
        step(1'b1, 32'hFFFF_FFF8);
        run(12);
        check("wrap_req0", (req_log.size() > 0) ? req_log[0] : 32'hx, 32'hFFFF_FFF8);
        check("wrap_req1", (req_log.size() > 1) ? req_log[1] : 32'hx, 32'hFFFF_FFFC);
        check("wrap_req2", (req_log.size() > 2) ? req_log[2] : 32'hx, 32'h0000_0000);
        check("wrap_pc1", (deq_log.size() > 1) ? deq_log[1] : 32'hx, 32'hFFFF_FFFC);
        check("wrap_pc2", (deq_log.size() > 2) ? deq_log[2] : 32'hx, 32'h0000_0000);

        // Randomized traffic with occasional redirects and mid-flight resets.
        for (int blk = 0; blk < 40; blk++) begin
            rdy_pct = $urandom_range(30, 100);
            rsp_pct = $urandom_range(20, 100);
            ifr_pct = $urandom_range(10, 100);
            if ($urandom_range(9) == 0) do_reset($urandom_range(1, 2));
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(11) == 0) begin
                    tgt = $urandom;
                    if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                    step(1'b1, tgt);
                end else begin
                    step(1'b0, 32'h0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
